// File: rtl/edit_mem_buf_chain_writer_pkg.sv
// rtl/edit_mem_buf_chain_writer_pkg.sv - shared widths and state encoding for the edit-memory chain writer
package edit_mem_buf_chain_writer_pkg;

  localparam int EM_BUF_PTR_NBITS     = 4;
  localparam int PD_CHUNK_DEPTH_NBITS = 14;
  localparam int DATA_PATH_NBYTES     = 64;

  typedef enum logic {
    EMW_INIT = 1'b0,
    EMW_RUN  = 1'b1
  } emw_state_e;

endpackage

// File: rtl/edit_mem_free_ptr_fifo.sv
// rtl/edit_mem_free_ptr_fifo.sv - first-word-fall-through free-pointer FIFO, RAM-based store
module edit_mem_free_ptr_fifo
  import edit_mem_buf_chain_writer_pkg::*;
#(
  parameter int AW = EM_BUF_PTR_NBITS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [AW-1:0] push_data,
  input  logic          pop,
  output logic [AW-1:0] head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [AW-1:0] mem [2**AW];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(2**AW));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_q];
  assign count   = cnt_q;

  // Storage carries no reset so it maps onto a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/edit_mem_buf_chain_writer.sv
// rtl/edit_mem_buf_chain_writer.sv - buffer allocator and linked-list chain builder for edit memory enqueue
module edit_mem_buf_chain_writer
  import edit_mem_buf_chain_writer_pkg::*;
#(
  parameter int BPTR_NBITS = EM_BUF_PTR_NBITS,
  parameter int LEN_NBITS  = PD_CHUNK_DEPTH_NBITS,
  parameter int SIZE       = DATA_PATH_NBYTES,
  parameter int NB_NBITS   = $clog2(SIZE) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chk_valid,
  input  logic                  chk_sop,
  input  logic                  chk_eop,
  input  logic [NB_NBITS-1:0]   chk_nbytes,
  output logic                  chk_ready,
  input  logic                  buf_free_valid,
  input  logic [BPTR_NBITS-1:0] buf_free_ptr,
  output logic                  em_wr_valid,
  output logic [BPTR_NBITS-1:0] em_wr_ptr,
  output logic                  enq_buf_valid,
  output logic [BPTR_NBITS-1:0] enq_buf_ptr_cur,
  output logic [BPTR_NBITS-1:0] enq_buf_ptr_nxt,
  output logic                  desc_valid,
  output logic [BPTR_NBITS-1:0] desc_head_ptr,
  output logic [LEN_NBITS-1:0]  desc_len,
  output logic [BPTR_NBITS:0]   free_cnt,
  output logic                  init_done,
  output logic                  free_err
);

  emw_state_e            state_q;
  logic [BPTR_NBITS-1:0] init_cnt_q;
  logic [BPTR_NBITS-1:0] cur_q, cur_d, pf_q, pf_d, head_q, pkt_head;
  logic                  cur_v_q, cur_v_d, pf_v_q, pf_v_d;
  logic [LEN_NBITS-1:0]  len_q, pkt_len, chunk_bytes;
  logic                  is_run, accept, free_push;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [BPTR_NBITS-1:0] fifo_wdata, fifo_head;

  edit_mem_free_ptr_fifo #(.AW(BPTR_NBITS)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (free_cnt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    is_run     = (state_q == EMW_RUN);
    accept     = chk_valid & chk_ready;
    free_push  = buf_free_valid & is_run & ~fifo_full;
    fifo_push  = is_run ? free_push : 1'b1;
    fifo_wdata = is_run ? buf_free_ptr : init_cnt_q;
    cur_d      = cur_q;
    cur_v_d    = cur_v_q;
    pf_d       = pf_q;
    pf_v_d     = pf_v_q;
    fifo_pop   = 1'b0;
    // One pop per cycle: an accept shifts pf into cur and refills pf; otherwise fill the empty slot.
    if (is_run) begin
      if (accept) begin
        cur_d   = pf_q;
        cur_v_d = 1'b1;
        if (!fifo_empty) begin
          pf_d     = fifo_head;
          fifo_pop = 1'b1;
        end else begin
          pf_v_d = 1'b0;
        end
      end else if (!cur_v_q && !fifo_empty) begin
        cur_d    = fifo_head;
        cur_v_d  = 1'b1;
        fifo_pop = 1'b1;
      end else if (!pf_v_q && !fifo_empty) begin
        pf_d     = fifo_head;
        pf_v_d   = 1'b1;
        fifo_pop = 1'b1;
      end
    end
    chunk_bytes = chk_eop ? LEN_NBITS'(chk_nbytes) : LEN_NBITS'(SIZE);
    pkt_head    = chk_sop ? cur_q : head_q;
    pkt_len     = (chk_sop ? '0 : len_q) + chunk_bytes;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= EMW_INIT;
      init_cnt_q      <= '0;
      cur_q           <= '0;
      cur_v_q         <= 1'b0;
      pf_q            <= '0;
      pf_v_q          <= 1'b0;
      head_q          <= '0;
      len_q           <= '0;
      chk_ready       <= 1'b0;
      init_done       <= 1'b0;
      em_wr_valid     <= 1'b0;
      em_wr_ptr       <= '0;
      enq_buf_valid   <= 1'b0;
      enq_buf_ptr_cur <= '0;
      enq_buf_ptr_nxt <= '0;
      desc_valid      <= 1'b0;
      desc_head_ptr   <= '0;
      desc_len        <= '0;
      free_err        <= 1'b0;
    end else begin
      if (state_q == EMW_INIT) begin
        init_cnt_q <= init_cnt_q + 1'b1;
        if (&init_cnt_q) begin
          state_q   <= EMW_RUN;
          init_done <= 1'b1;
        end
      end
      cur_q     <= cur_d;
      cur_v_q   <= cur_v_d;
      pf_q      <= pf_d;
      pf_v_q    <= pf_v_d;
      chk_ready <= is_run & cur_v_d & pf_v_d;
      free_err  <= buf_free_valid & ~free_push;

      em_wr_valid   <= accept;
      enq_buf_valid <= accept & ~chk_eop;
      desc_valid    <= accept & chk_eop;
      if (accept) begin
        em_wr_ptr <= cur_q;
        head_q    <= pkt_head;
        len_q     <= pkt_len;
        if (!chk_eop) begin
          enq_buf_ptr_cur <= cur_q;
          enq_buf_ptr_nxt <= pf_q;
        end else begin
          desc_head_ptr <= pkt_head;
          desc_len      <= pkt_len;
        end
      end
    end
  end

endmodule

// File: tb/tb_edit_mem_buf_chain_writer.sv
// tb/tb_edit_mem_buf_chain_writer.sv - directed self-checking bench for edit_mem_buf_chain_writer
module tb_edit_mem_buf_chain_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        chk_valid, chk_sop, chk_eop;
  logic [6:0]  chk_nbytes;
  logic        chk_ready;
  logic        buf_free_valid;
  logic [3:0]  buf_free_ptr;
  logic        em_wr_valid;
  logic [3:0]  em_wr_ptr;
  logic        enq_buf_valid;
  logic [3:0]  enq_buf_ptr_cur, enq_buf_ptr_nxt;
  logic        desc_valid;
  logic [3:0]  desc_head_ptr;
  logic [13:0] desc_len;
  logic [4:0]  free_cnt;
  logic        init_done, free_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  edit_mem_buf_chain_writer dut (
    .clk(clk), .rst(rst),
    .chk_valid(chk_valid), .chk_sop(chk_sop), .chk_eop(chk_eop),
    .chk_nbytes(chk_nbytes), .chk_ready(chk_ready),
    .buf_free_valid(buf_free_valid), .buf_free_ptr(buf_free_ptr),
    .em_wr_valid(em_wr_valid), .em_wr_ptr(em_wr_ptr),
    .enq_buf_valid(enq_buf_valid), .enq_buf_ptr_cur(enq_buf_ptr_cur),
    .enq_buf_ptr_nxt(enq_buf_ptr_nxt),
    .desc_valid(desc_valid), .desc_head_ptr(desc_head_ptr), .desc_len(desc_len),
    .free_cnt(free_cnt), .init_done(init_done), .free_err(free_err)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    chk_valid = 0; chk_sop = 0; chk_eop = 0; chk_nbytes = '0;
    buf_free_valid = 0; buf_free_ptr = '0;
  endtask

  task automatic reinit();
    idle_inputs();
    rst = 1; tick(); tick();
    rst = 0;
    repeat (18) tick();
  endtask

  task automatic send(input logic sop, input logic eop, input logic [6:0] nb);
    chk_valid = 1; chk_sop = sop; chk_eop = eop; chk_nbytes = nb;
    tick();
    chk_valid = 0; chk_sop = 0; chk_eop = 0; chk_nbytes = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; tick(); tick();
    checks++;
    if ({chk_ready, em_wr_valid, enq_buf_valid, desc_valid, free_err, init_done} !== 6'b0 ||
        free_cnt !== 5'd0 || em_wr_ptr !== 4'd0 || desc_len !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b wr=%b enq=%b desc=%b err=%b done=%b cnt=%0d, required all 0",
               chk_ready, em_wr_valid, enq_buf_valid, desc_valid, free_err, init_done, free_cnt);
    end
    rst = 0;
    for (int c = 1; c <= 18; c++) begin
      if (c == 4) begin buf_free_valid = 1; buf_free_ptr = 4'd9; end
      tick();
      buf_free_valid = 0;
      if (c == 4) begin
        checks++;
        if (free_err !== 1'b1) begin errors++; $display("FAIL init_free_err: got %b required 1", free_err); end
      end
      if (c == 5) begin
        checks++;
        if (free_err !== 1'b0) begin errors++; $display("FAIL init_free_err_pulse: got %b required 0", free_err); end
      end
      if (c == 15) begin
        checks++;
        if (init_done !== 1'b0) begin errors++; $display("FAIL init_done_early: got %b required 0", init_done); end
      end
      if (c == 16) begin
        checks++;
        if (init_done !== 1'b1 || free_cnt !== 5'd16) begin
          errors++; $display("FAIL init_end: done=%b cnt=%0d required 1 16", init_done, free_cnt);
        end
      end
      if (c == 17) begin
        checks++;
        if (chk_ready !== 1'b0) begin errors++; $display("FAIL ready_early: got %b required 0", chk_ready); end
      end
      if (c == 18) begin
        checks++;
        if (chk_ready !== 1'b1) begin errors++; $display("FAIL ready_cycle18: got %b required 1", chk_ready); end
      end
    end
  endtask

  task automatic test_single_chunk();
    reinit();
    send(1, 1, 7'd5);
    checks++;
    if (em_wr_valid !== 1'b1 || em_wr_ptr !== 4'd0 || enq_buf_valid !== 1'b0 ||
        desc_valid !== 1'b1 || desc_head_ptr !== 4'd0 || desc_len !== 14'd5) begin
      errors++;
      $display("FAIL single_chunk: wr=%b ptr=%0d enq=%b desc=%b head=%0d len=%0d required 1 0 0 1 0 5",
               em_wr_valid, em_wr_ptr, enq_buf_valid, desc_valid, desc_head_ptr, desc_len);
    end
    tick();
    checks++;
    if (em_wr_valid !== 1'b0 || desc_valid !== 1'b0) begin
      errors++; $display("FAIL single_pulse: wr=%b desc=%b required 0 0", em_wr_valid, desc_valid);
    end
  endtask

  task automatic test_three_chunks();
    logic [3:0] exp_nxt [3];
    exp_nxt[0] = 4'd1; exp_nxt[1] = 4'd2; exp_nxt[2] = 4'd0;
    reinit();
    for (int k = 0; k < 3; k++) begin
      send(k == 0, k == 2, (k == 2) ? 7'd7 : 7'd0);
      checks++;
      if (em_wr_valid !== 1'b1 || em_wr_ptr !== 4'(k) || enq_buf_valid !== (k != 2) ||
          (k != 2 && (enq_buf_ptr_cur !== 4'(k) || enq_buf_ptr_nxt !== exp_nxt[k]))) begin
        errors++;
        $display("FAIL three_chunk_%0d: wr=%b ptr=%0d enq=%b %0d->%0d required ptr %0d link %0d->%0d",
                 k, em_wr_valid, em_wr_ptr, enq_buf_valid, enq_buf_ptr_cur, enq_buf_ptr_nxt, k, k, exp_nxt[k]);
      end
    end
    checks++;
    if (desc_valid !== 1'b1 || desc_head_ptr !== 4'd0 || desc_len !== 14'd135) begin
      errors++;
      $display("FAIL three_chunk_desc: v=%b head=%0d len=%0d required 1 0 135", desc_valid, desc_head_ptr, desc_len);
    end
  endtask

  task automatic test_back_to_back();
    reinit();
    buf_free_valid = 1; buf_free_ptr = 4'd0;
    send(1, 0, 7'd0);
    buf_free_valid = 0;
    checks++;
    if (free_cnt !== 5'd14 || em_wr_ptr !== 4'd0) begin
      errors++; $display("FAIL free_and_pop: cnt=%0d ptr=%0d required 14 0", free_cnt, em_wr_ptr);
    end
  endtask

  task automatic test_exhaustion();
    reinit();
    for (int k = 0; k < 15; k++) begin
      checks++;
      if (chk_ready !== 1'b1) begin errors++; $display("FAIL exh_ready_%0d: got %b required 1", k, chk_ready); end
      send(k == 0, 0, 7'd0);
      checks++;
      if (em_wr_ptr !== 4'(k)) begin errors++; $display("FAIL exh_ptr_%0d: got %0d required %0d", k, em_wr_ptr, k); end
    end
    checks++;
    if (chk_ready !== 1'b0 || free_cnt !== 5'd0) begin
      errors++; $display("FAIL exh_ready_low: rdy=%b cnt=%0d required 0 0", chk_ready, free_cnt);
    end
    buf_free_valid = 1; buf_free_ptr = 4'd3;
    tick();
    buf_free_valid = 0;
    checks++;
    if (chk_ready !== 1'b0 || free_cnt !== 5'd1) begin
      errors++; $display("FAIL exh_free: rdy=%b cnt=%0d required 0 1", chk_ready, free_cnt);
    end
    tick();
    checks++;
    if (chk_ready !== 1'b1) begin errors++; $display("FAIL exh_ready_back: got %b required 1", chk_ready); end
    send(0, 0, 7'd0);
    checks++;
    if (em_wr_ptr !== 4'd15 || enq_buf_ptr_cur !== 4'd15 || enq_buf_ptr_nxt !== 4'd3) begin
      errors++;
      $display("FAIL exh_next_pf: ptr=%0d link %0d->%0d required 15 15->3", em_wr_ptr, enq_buf_ptr_cur, enq_buf_ptr_nxt);
    end
  endtask

  task automatic test_free_full();
    reinit();
    for (int k = 0; k < 3; k++) begin
      buf_free_valid = 1; buf_free_ptr = 4'(7 + k);
      tick();
      buf_free_valid = 0;
      checks++;
      if (free_err !== (k == 2) || free_cnt !== ((k == 0) ? 5'd15 : 5'd16)) begin
        errors++;
        $display("FAIL free_full_%0d: err=%b cnt=%0d required %b %0d", k, free_err, free_cnt, k == 2, (k == 0) ? 15 : 16);
      end
    end
    tick();
    checks++;
    if (free_err !== 1'b0) begin errors++; $display("FAIL free_full_pulse: got %b required 0", free_err); end
  endtask

  task automatic test_reset_mid_packet();
    int seen_desc = 0;
    reinit();
    send(1, 0, 7'd0);
    send(0, 0, 7'd0);
    rst = 1;
    tick();
    checks++;
    if ({chk_ready, em_wr_valid, enq_buf_valid, desc_valid, init_done} !== 5'b0 ||
        free_cnt !== 5'd0 || em_wr_ptr !== 4'd0 || enq_buf_ptr_cur !== 4'd0) begin
      errors++;
      $display("FAIL midrst_outputs: rdy=%b wr=%b enq=%b desc=%b done=%b cnt=%0d ptr=%0d required zeros",
               chk_ready, em_wr_valid, enq_buf_valid, desc_valid, init_done, free_cnt, em_wr_ptr);
    end
    rst = 0;
    for (int c = 1; c <= 18; c++) begin
      tick();
      if (desc_valid) seen_desc++;
    end
    checks++;
    if (seen_desc != 0 || free_cnt !== 5'd14 || chk_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_reinit: desc=%0d cnt=%0d rdy=%b required 0 14 1", seen_desc, free_cnt, chk_ready);
    end
    send(1, 1, 7'd64);
    checks++;
    if (desc_valid !== 1'b1 || desc_head_ptr !== 4'd0 || desc_len !== 14'd64) begin
      errors++;
      $display("FAIL midrst_next_pkt: v=%b head=%0d len=%0d required 1 0 64", desc_valid, desc_head_ptr, desc_len);
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_single_chunk();
    test_three_chunks();
    test_back_to_back();
    test_exhaustion();
    test_free_full();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
